// File: rtl/framebuffer_clear_engine.sv
// Multi-lane back-buffer clear: fills with a two-colour split pattern, LANES pixels per granted beat.
// First beat appears two cycles after start; grant=0 freezes all outputs; abort drops straight to idle.
module framebuffer_clear_engine #(
  parameter int DEPTH  = 307200,
  parameter int LANES  = 2,
  parameter int DATA_W = 4,
  parameter int ADDR_W = 19
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     i_grant,
  input  logic [ADDR_W-1:0]        i_split_addr,
  input  logic [DATA_W-1:0]        i_colour_top,
  input  logic [DATA_W-1:0]        i_colour_bottom,
  output logic [LANES-1:0]         o_wr_en,
  output logic [LANES*ADDR_W-1:0]  o_wr_addr,
  output logic [LANES*DATA_W-1:0]  o_wr_data,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int BW = ADDR_W + 1;
  localparam logic [BW-1:0] W_DEPTH = BW'(DEPTH);
  localparam logic [BW-1:0] W_LANES = BW'(LANES);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [BW-1:0]             r_base, w_base_nxt;
  logic [ADDR_W-1:0]         r_split;
  logic [DATA_W-1:0]         r_top, r_bottom;
  logic [LANES-1:0]          r_wr_en, w_wr_en_nxt;
  logic [LANES*ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic [LANES*DATA_W-1:0]   r_wr_data, w_wr_data_nxt;
  logic [BW-1:0]             w_lane_addr;
  logic                      w_beat, w_last, w_load;

  always_comb begin
    w_beat      = (r_state == S_FILL) && (r_wr_en != '0) && i_grant && !i_abort;
    w_last      = w_beat && ((r_base + W_LANES) >= W_DEPTH);
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_FILL;
          w_base_nxt  = '0;
        end
      end
      S_FILL: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_beat) begin
          w_base_nxt = r_base + W_LANES;
          if (w_last) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The accept cycle only clears base; lanes load from the first FILL cycle onward.
  assign w_load = (r_state == S_FILL) && (w_state_nxt == S_FILL);

  always_comb begin
    w_lane_addr   = '0;
    w_wr_en_nxt   = '0;
    w_wr_addr_nxt = '0;
    w_wr_data_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane_addr = w_base_nxt + BW'(i);
      w_wr_en_nxt[i] = w_load && (w_lane_addr < W_DEPTH);
      w_wr_addr_nxt[i*ADDR_W +: ADDR_W] = w_lane_addr[ADDR_W-1:0];
      w_wr_data_nxt[i*DATA_W +: DATA_W] = (w_lane_addr < {1'b0, r_split}) ? r_top : r_bottom;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_split   <= '0;
      r_top     <= '0;
      r_bottom  <= '0;
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_wr_en <= w_wr_en_nxt;
      if (w_load) begin
        r_wr_addr <= w_wr_addr_nxt;
        r_wr_data <= w_wr_data_nxt;
      end
      if ((r_state == S_IDLE) && i_start) begin
        r_split  <= i_split_addr;
        r_top    <= i_colour_top;
        r_bottom <= i_colour_bottom;
      end
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);

endmodule

// File: tb/tb_framebuffer_clear_engine.sv
// Bench for framebuffer_clear_engine: a 16-pixel and a 10-pixel instance, four lanes each.
module tb_framebuffer_clear_engine;

  typedef struct packed {
    logic [4:0] addr;
    logic [3:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n, start_a, start_b, abort, grant;
  logic [4:0]  split;
  logic [3:0]  ctop, cbot;
  logic [3:0]  en_a, en_b;
  logic [19:0] addr_a, addr_b;
  logic [15:0] data_a, data_b;
  logic        busy_a, busy_b, done_a, done_b;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  done_cnt[2];
  int  done_cyc[2];
  int  beats[2];
  int  s_cyc, d0, b0;
  wr_t q_a[$];
  wr_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  framebuffer_clear_engine #(.DEPTH(16), .LANES(4), .DATA_W(4), .ADDR_W(5)) u_dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start_a), .i_abort(abort), .i_grant(grant),
    .i_split_addr(split), .i_colour_top(ctop), .i_colour_bottom(cbot),
    .o_wr_en(en_a), .o_wr_addr(addr_a), .o_wr_data(data_a), .o_busy(busy_a), .o_done(done_a));

  framebuffer_clear_engine #(.DEPTH(10), .LANES(4), .DATA_W(4), .ADDR_W(5)) u_dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start_b), .i_abort(abort), .i_grant(grant),
    .i_split_addr(split), .i_colour_top(ctop), .i_colour_bottom(cbot),
    .o_wr_en(en_b), .o_wr_addr(addr_b), .o_wr_data(data_b), .o_busy(busy_b), .o_done(done_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_beat(input int id, input logic [3:0] en, input logic [19:0] addr,
                          input logic [15:0] data);
    wr_t        e;
    logic [4:0] a;
    logic [3:0] d;
    int         depth;
    depth = (id == 0) ? 16 : 10;
    beats[id]++;
    if (id == 1 && addr[4:0] == 5'd8) check("final_mask", 32'(en), 32'b0011);
    for (int l = 0; l < 4; l++) begin
      if (en[l]) begin
        a = addr[l*5 +: 5];
        d = data[l*4 +: 4];
        check("addr_in_range", 32'(int'(a) < depth), 1);
        if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write dut%0d: got addr %0d, expected no write", id, a);
        end else begin
          if (id == 0) e = q_a.pop_front();
          else         e = q_b.pop_front();
          check("wr_addr", 32'(a), 32'(e.addr));
          check("wr_data", 32'(d), 32'(e.data));
        end
      end
    end
  endtask

  // Pushes the first n_exp expected writes, then pulses start for one cycle.
  task automatic start_dut(input int id, input int sp, input int top, input int bot, input int n_exp);
    wr_t e;
    for (int a = 0; a < n_exp; a++) begin
      e.addr = 5'(a);
      e.data = (a < sp) ? 4'(top) : 4'(bot);
      if (id == 0) q_a.push_back(e);
      else         q_b.push_back(e);
    end
    split = 5'(sp);
    ctop  = 4'(top);
    cbot  = 4'(bot);
    if (id == 0) start_a = 1'b1;
    else         start_b = 1'b1;
    s_cyc = cyc;
    d0    = done_cnt[id];
    b0    = beats[id];
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    check("busy_after_start", 32'((id == 0) ? busy_a : busy_b), 1);
  endtask

  task automatic wait_done(input int id, input int exp_lat, input int exp_beats);
    int n = 0;
    while (done_cnt[id] == d0 && n < 200) begin
      tick();
      n++;
    end
    if (done_cnt[id] == d0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout dut%0d: got no done within 200 cycles, expected one", id);
    end else begin
      check("done_latency", 32'(done_cyc[id] - s_cyc), 32'(exp_lat));
      check("beat_count", 32'(beats[id] - b0), 32'(exp_beats));
      check("busy_after_done", 32'((id == 0) ? busy_a : busy_b), 0);
      check("done_one_cycle", 32'((id == 0) ? done_a : done_b), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; grant = 1'b1;
    split = '0; ctop = '0; cbot = '0;
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; done_cyc[i] = 0; beats[i] = 0;
    end

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (done_a) begin done_cnt[0]++; done_cyc[0] = cyc; end
          if (done_b) begin done_cnt[1]++; done_cyc[1] = cyc; end
          if (en_a != 4'd0 && grant && !abort) mon_beat(0, en_a, addr_a, data_a);
          if (en_b != 4'd0 && grant && !abort) mon_beat(1, en_b, addr_b, data_b);
        end
      end
    join_none

    // Reset state
    repeat (2) tick();
    check("rst_wr_en", 32'(en_a), 0);
    check("rst_wr_addr", addr_a, 0);
    check("rst_wr_data", 32'(data_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic split fill, 4 beats, done 6 cycles after start
    start_dut(0, 6, 0, 1, 16);
    wait_done(0, 6, 4);

    // Non-multiple depth: beats at 0,4,8, last mask 0011
    start_dut(1, 3, 5, 10, 10);
    wait_done(1, 5, 3);

    // Three-cycle stall on the second beat
    start_dut(0, 6, 0, 1, 16);
    tick();
    tick();
    grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_wr_en", 32'(en_a), 32'hF);
      check("stall_addr", 32'(addr_a[4:0]), 4);
      check("stall_data", 32'(data_a), 32'h1100);
      tick();
    end
    grant = 1'b1;
    check("stall_release_addr", 32'(addr_a[4:0]), 4);
    wait_done(0, 9, 4);

    // Abort on the second beat; only the first beat is written
    start_dut(0, 6, 0, 1, 4);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_wr_en", 32'(en_a), 0);
    check("abort_busy", 32'(busy_a), 0);
    repeat (8) tick();
    check("abort_no_done", 32'(done_cnt[0] - d0), 0);
    check("abort_queue_empty", 32'(q_a.size()), 0);
    start_dut(0, 6, 0, 1, 16);
    wait_done(0, 6, 4);

    // split=0 -> all bottom; split=DEPTH -> all top, with a start pulsed during FILL
    start_dut(0, 0, 3, 12, 16);
    wait_done(0, 6, 4);
    start_dut(0, 16, 7, 2, 16);
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(0, 6, 4);
    repeat (4) tick();
    check("ignored_start_idle", 32'(busy_a), 0);

    // Reset mid-fill
    start_dut(0, 6, 0, 1, 4);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 32'(en_a), 0);
    check("midrst_wr_addr", addr_a, 0);
    check("midrst_wr_data", 32'(data_a), 0);
    check("midrst_busy", 32'(busy_a), 0);
    check("midrst_queue_empty", 32'(q_a.size()), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("postrst_busy", 32'(busy_a), 0);
      check("postrst_done", 32'(done_a), 0);
    end
    start_dut(0, 9, 4, 8, 16);
    wait_done(0, 6, 4);

    repeat (3) tick();
    check("final_queue_a", 32'(q_a.size()), 0);
    check("final_queue_b", 32'(q_b.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
